// File: rtl/rbc_codec.sv
// Registered reflected-binary-code (Gray) converter.
// The forward lane encodes binary to RBC and the reverse lane decodes RBC to binary.
// Both lanes convert combinationally. Their results, plus the parity of the encoded
// word, are captured once per valid cycle. A single-stage valid pipe runs alongside
// the data.

// One conversion lane. P_DECODE selects the direction.
module rbc_cvt #(
  parameter int P_WIDTH  = 8,
  parameter bit P_DECODE = 1'b0
) (
  input  logic [P_WIDTH-1:0] din,
  output logic [P_WIDTH-1:0] dout
);

  if (P_DECODE) begin : g_dec
    // Each binary bit is the XOR of every RBC bit at or above it, taken MSB downward.
    for (genvar i = 0; i < P_WIDTH; i++) begin : g_bit
      assign dout[i] = ^din[P_WIDTH-1:i];
    end
  end else begin : g_enc
    // Each RBC bit marks a change between adjacent binary bits. The MSB passes through.
    assign dout = din ^ (din >> 1);
  end

endmodule

module rbc_codec #(
  parameter int P_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  input  logic [P_WIDTH-1:0] iv_bin,
  input  logic [P_WIDTH-1:0] iv_rbc,
  output logic               o_valid,
  output logic [P_WIDTH-1:0] ov_rbc,
  output logic [P_WIDTH-1:0] ov_bin,
  output logic               o_parity
);

  if (P_WIDTH < 1 || P_WIDTH > 32) begin : g_bad_width
    $error("rbc_codec: P_WIDTH must be in 1..32");
  end

  localparam int STAGES = 1;

  typedef struct packed {
    logic [P_WIDTH-1:0] rbc;
    logic [P_WIDTH-1:0] bin;
    logic               parity;
  } res_t;

  res_t               res_d;
  res_t               res_q;
  logic [STAGES:0]    vld_pipe;
  logic [P_WIDTH-1:0] enc;
  logic [P_WIDTH-1:0] dec;

  rbc_cvt #(.P_WIDTH(P_WIDTH), .P_DECODE(1'b0)) u_enc (.din(iv_bin), .dout(enc));
  rbc_cvt #(.P_WIDTH(P_WIDTH), .P_DECODE(1'b1)) u_dec (.din(iv_rbc), .dout(dec));

  // The parity of the encoded word equals bin[0]. Computing it from the RBC side
  // keeps the output self-consistent with ov_rbc.
  assign res_d.rbc    = enc;
  assign res_d.bin    = dec;
  assign res_d.parity = ^enc;

  assign vld_pipe[0] = i_valid;

  // Capture on valid cycles only, so the data holds (and ignores junk inputs) while
  // idle. Reset clears everything and wins over valid.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      res_q              <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (i_valid) res_q <= res_d;
    end
  end

  assign o_valid  = vld_pipe[STAGES];
  assign ov_rbc   = res_q.rbc;
  assign ov_bin   = res_q.bin;
  assign o_parity = res_q.parity;

endmodule

// File: tb/tb_rbc_codec.sv
// Bench for rbc_codec.
// The main DUT runs at width 4 against a Gray-table model built by reflection,
// with an every-cycle compare. Literal vectors pin the model. A second set of DUTs
// at widths 1..5 loop ov_rbc back into iv_rbc to check the round trip.
module tb_rbc_codec;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         vld;
  logic [W-1:0] bin_in;
  logic [W-1:0] rbc_in;
  logic         o_vld;
  logic [W-1:0] o_rbc;
  logic [W-1:0] o_bin;
  logic         o_par;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rbc_codec #(.P_WIDTH(W)) u_dut (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .iv_bin(bin_in), .iv_rbc(rbc_in),
    .o_valid(o_vld), .ov_rbc(o_rbc), .ov_bin(o_bin), .o_parity(o_par)
  );

  // Round-trip instances, widths 1..5. Each instance feeds its own RBC output
  // back into its decode input.
  logic [4:0] rt_x;
  logic       rt_par [1:5];
  logic       rt_vld [1:5];
  logic [4:0] rt_bo  [1:5];

  for (genvar k = 1; k <= 5; k++) begin : g_rt
    logic [k-1:0] lb_rbc;
    logic [k-1:0] lb_bin;
    rbc_codec #(.P_WIDTH(k)) u_rt (
      .i_clk(clk), .i_reset(rst), .i_valid(1'b1), .iv_bin(rt_x[k-1:0]), .iv_rbc(lb_rbc),
      .o_valid(rt_vld[k]), .ov_rbc(lb_rbc), .ov_bin(lb_bin), .o_parity(rt_par[k])
    );
    assign rt_bo[k] = 5'(lb_bin);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Gray sequence built by reflection: the second half is the first half mirrored,
  // with the new top bit set. Position in the table is the binary value.
  int gray_tbl [16];

  function automatic int gray_index(input logic [W-1:0] r);
    for (int i = 0; i < 16; i++) if (gray_tbl[i] == int'(r)) return i;
    return -1;
  endfunction

  // Behavioural model of the registered outputs.
  logic         m_vld, m_par, m_live = 1'b0;
  logic [W-1:0] m_rbc, m_bin;

  // Model state update on every rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_vld <= 1'b0; m_rbc <= '0; m_bin <= '0; m_par <= 1'b0; m_live <= 1'b1;
    end else if (vld) begin
      m_vld <= 1'b1;
      m_rbc <= W'(gray_tbl[bin_in]);
      m_bin <= W'(gray_index(rbc_in));
      m_par <= bin_in[0];
    end else begin
      m_vld <= 1'b0;
    end
  end

  // Every-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("cmp_valid",  32'(o_vld), 32'(m_vld));
      chk("cmp_rbc",    32'(o_rbc), 32'(m_rbc));
      chk("cmp_bin",    32'(o_bin), 32'(m_bin));
      chk("cmp_parity", 32'(o_par), 32'(m_par));
    end
  end

  logic [W-1:0] sweep_exp [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  logic [W-1:0] prev_rbc;
  logic [W-1:0] dec_in  [3] = '{4'b0111, 4'b1000, 4'b1100};
  logic [W-1:0] dec_exp [3] = '{4'b0101, 4'b1111, 4'b1000};

  initial begin
    int n;
    gray_tbl[0] = 0;
    n = 1;
    for (int b = 0; b < W; b++) begin
      for (int i = 0; i < n; i++) gray_tbl[n+i] = gray_tbl[n-1-i] | (1 << b);
      n = n * 2;
    end

    rst = 1'b1; vld = 1'b0; bin_in = '0; rbc_in = '0; rt_x = '0;
    @(negedge clk);

    // Reset wins over valid.
    rst = 1'b1; vld = 1'b1; bin_in = 4'hF; rbc_in = 4'hF;
    @(negedge clk);
    chk("reset_valid",  32'(o_vld), 0);
    chk("reset_rbc",    32'(o_rbc), 0);
    chk("reset_bin",    32'(o_bin), 0);
    chk("reset_parity", 32'(o_par), 0);
    rst = 1'b0;

    // Back-to-back encode sweep, including the 15 -> 0 wrap.
    for (int i = 0; i <= 16; i++) begin
      vld = 1'b1; bin_in = W'(i); rbc_in = W'(i * 7 + 3);
      @(negedge clk);
      chk("sweep_valid",  32'(o_vld), 1);
      chk("sweep_rbc",    32'(o_rbc), 32'(sweep_exp[i % 16]));
      chk("sweep_parity", 32'(o_par), 32'(i & 1));
      if (i > 0) chk("sweep_onebit", 32'($countones(o_rbc ^ prev_rbc)), 1);
      prev_rbc = o_rbc;
    end

    // Literal decode vectors.
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; bin_in = W'(i); rbc_in = dec_in[i];
      @(negedge clk);
      chk("decode_bin", 32'(o_bin), 32'(dec_exp[i]));
    end

    // Hold: idle cycles with changing or undefined inputs leave data alone.
    vld = 1'b1; bin_in = 4'd5; rbc_in = 4'd0;
    @(negedge clk);
    chk("hold_first_rbc", 32'(o_rbc), 32'(4'b0111));
    for (int i = 0; i < 3; i++) begin
      vld = 1'b0; bin_in = (i == 0) ? 4'd9 : 'x; rbc_in = 'x;
      @(negedge clk);
      chk("hold_rbc",    32'(o_rbc), 32'(4'b0111));
      chk("hold_valid",  32'(o_vld), 0);
      chk("hold_parity", 32'(o_par), 1);
    end

    // Mid-stream reset pulse on an otherwise continuous stream.
    for (int i = 0; i < 6; i++) begin
      vld = 1'b1; bin_in = W'(i + 3); rbc_in = W'(i); rst = (i == 2);
      @(negedge clk);
      if (i == 1) chk("mid_pre_rbc", 32'(o_rbc), 32'(4'd6));
      if (i == 2) begin
        chk("mid_rst_valid", 32'(o_vld), 0);
        chk("mid_rst_rbc",   32'(o_rbc), 0);
      end
      if (i == 3) begin
        chk("mid_post_valid", 32'(o_vld), 1);
        chk("mid_post_rbc",   32'(o_rbc), 32'(4'd5));
      end
    end
    rst = 1'b0;

    // Round trip at widths 1..5, every value at each width.
    for (int j = 0; j <= 32; j++) begin
      rt_x = 5'(j % 32);
      @(negedge clk);
      for (int k = 1; k <= 5; k++) begin
        chk("rt_parity", 32'(rt_par[k]), 32'(j & 1));
        chk("rt_valid",  32'(rt_vld[k]), 1);
        if (j > 0) chk("rt_bin", 32'(rt_bo[k]), 32'(((j - 1) % 32) & ((1 << k) - 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rbc_codec.md
Name: rbc_codec

Overview:
- Registered reflected-binary-code (RBC, Gray code) converter with two independent lanes.
- The forward lane maps binary to RBC. The reverse lane maps RBC to binary.
- Used wherever counters or pointers cross into RBC form (e.g. clock-domain pointer exchange) and back.
- The conversion itself is combinational. Results are registered once on the single clock, with a valid flag carried alongside.

Parameters:
- P_WIDTH, default 8, code width in bits; legal range 1..32; a value below 1 is a compile-time error.

Ports:
- i_clk  input  1  sole clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  qualifies iv_bin and iv_rbc this cycle.
- iv_bin  input  P_WIDTH  binary value to encode.
- iv_rbc  input  P_WIDTH  RBC value to decode.
- o_valid  output  1  ov_rbc, ov_bin and o_parity hold a new result.
- ov_rbc  output  P_WIDTH  RBC encoding of the captured iv_bin.
- ov_bin  output  P_WIDTH  binary decoding of the captured iv_rbc.
- o_parity  output  1  XOR-reduction of ov_rbc; always equals the LSB of the binary value that produced it.

Behaviour:
- Encode (forward lane):
  - rbc[P_WIDTH-1] = bin[P_WIDTH-1].
  - rbc[i] = bin[i] ^ bin[i+1] for i < P_WIDTH-1.
  - Equivalently, rbc = bin ^ (bin >> 1).
- Decode (reverse lane):
  - bin[P_WIDTH-1] = rbc[P_WIDTH-1].
  - bin[i] = bin[i+1] ^ rbc[i], i.e. a prefix XOR from the MSB down.
- Round-trip: decode(encode(x)) == x for all 2^P_WIDTH values of x.
- Parity: ^encode(x) == x[0] for all x.
- P_WIDTH = 1 degenerates to the identity in both directions.
- Latency: exactly 1 clock.
  - On a rising edge with i_valid=1 and i_reset=0, the outputs capture the results for that cycle's inputs and o_valid becomes 1.
- Hold: on a rising edge with i_valid=0 and i_reset=0:
  - o_valid becomes 0.
  - ov_rbc, ov_bin and o_parity keep their previous values (no toggling on invalid cycles).
- Lane independence: iv_bin and iv_rbc are unrelated inputs and are processed in the same cycle without interaction.
- Reset: on a rising edge with i_reset=1, o_valid=0, ov_rbc=0, ov_bin=0 and o_parity=0.
  - Reset takes priority over i_valid.
  - Reset asserted mid-stream discards the in-flight result.
  - The first valid input after reset release produces output one cycle later.
- Back-to-back: i_valid held high gives one result per clock with no bubbles. There is no backpressure and no ready signal.
- Wrap-around: encoding consecutive binary values including the 2^P_WIDTH-1 -> 0 wrap changes exactly one RBC bit per step.
- X/undefined inputs on an i_valid=0 cycle must not disturb the held outputs.

Test Plan:
- Reset: assert i_reset with i_valid=1 and iv_bin=4'hF → next edge o_valid=0, ov_rbc=0, ov_bin=0, o_parity=0.
- Encode sweep, P_WIDTH=4, iv_bin 0..15 with i_valid=1 each cycle:
  - Expected ov_rbc one cycle later: 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8.
  - Each step differs from the previous in exactly one bit, including 8 → 0 at the wrap.
  - o_parity equals iv_bin[0].
- Decode: iv_rbc=4'b0111 → ov_bin=4'b0101; iv_rbc=4'b1000 → ov_bin=4'b1111; iv_rbc=4'b1100 → ov_bin=4'b1000.
- Round-trip, P_WIDTH 1..5: feed ov_rbc back into iv_rbc for every value 0..2^P_WIDTH-1 → ov_bin equals the original value; o_parity equals its LSB.
- Hold: present iv_bin=5 with i_valid=1, then i_valid=0 with iv_bin=9 for 3 cycles → ov_rbc stays 4'b0111 and o_valid=0 on those cycles.
- Reset mid-stream: continuous valid stream, pulse i_reset for one cycle → outputs zero that cycle; the next valid input appears after exactly 1 clock.
